// File: rtl/pacoblaze_register_dump.sv
// pacoblaze_register_dump
// Debug readout engine for the PacoBlaze register file. Walks a wrapping
// address range through the spare asynchronous read port and streams each
// register value, tagged with its address, toward the host debug link.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_addr/out_last hold stable and the read pointer does not move.
// out_valid only drops after a transfer, or on abort/reset.

module pacoblaze_register_dump #(
    parameter int REG_DEPTH = 4,
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [REG_DEPTH-1:0] first_addr,
    input  logic [REG_DEPTH-1:0] last_addr,
    output logic [REG_DEPTH-1:0] rf_address,
    input  logic [REG_WIDTH-1:0] rf_data,
    output logic [REG_WIDTH-1:0] out_data,
    output logic [REG_DEPTH-1:0] out_addr,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [REG_DEPTH:0]   COUNT_ONE = {{REG_DEPTH{1'b0}}, 1'b1};
    localparam logic [REG_DEPTH-1:0] ADDR_ONE  = {{(REG_DEPTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    state_t               state_d;
    logic [REG_DEPTH:0]   count_q;     // words still to be loaded
    logic [REG_DEPTH:0]   count_init;
    logic                 accept;      // start taken in IDLE
    logic                 load;        // capture rf_data into the output slot
    logic                 final_load;  // the word being loaded is the last one
    logic                 finish;      // final word handed over
    logic                 kill;        // abort of a running dump

    // Range length; the subtraction wraps so last < first runs through the top.
    assign count_init = {1'b0, last_addr - first_addr} + COUNT_ONE;

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; abort takes priority over any handshake.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        load       = 1'b0;
        final_load = 1'b0;
        finish     = 1'b0;
        kill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (count_q == COUNT_ONE) begin
                        final_load = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    kill    = 1'b1;
                    state_d = IDLE;
                end else if (out_valid && out_ready) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read pointer, remaining count and the single-entry output slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_address <= '0;
            count_q    <= '0;
            out_data   <= '0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                rf_address <= first_addr;
                count_q    <= count_init;
            end
            if (load) begin
                // The word reflects the register contents in this very cycle,
                // so core writes to not-yet-loaded registers show up.
                out_data   <= rf_data;
                out_addr   <= rf_address;
                out_valid  <= 1'b1;
                out_last   <= final_load;
                rf_address <= rf_address + ADDR_ONE;
                count_q    <= count_q - COUNT_ONE;
            end
            if (kill || finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pacoblaze_register_dump.sv
// tb_pacoblaze_register_dump
// Bench for the register dump engine: a register file model driven by the
// bench, a scoreboard of expected {last, addr, data} words, and a monitor
// that compares every transferred word against the queue.

module tb_pacoblaze_register_dump;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic [3:0] rf_address;
    logic [7:0] rf_data;
    logic [7:0] out_data;
    logic [3:0] out_addr;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    logic [7:0]  rf  [16];   // register file seen by the DUT
    logic [7:0]  mdl [16];   // contents each word is expected to carry
    logic [12:0] exp_q[$];

    int n_checks;
    int n_err;
    int cyc;
    int t0;
    int hs_count;
    int first_hs_k;
    int last_hs_k;
    int done_k;
    int done_cnt;
    bit done_pend;
    bit held_v;
    logic [12:0] held_word;

    assign rf_data = rf[rf_address];

    pacoblaze_register_dump #(.REG_DEPTH(4), .REG_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_address (rf_address),
        .rf_data    (rf_data),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares transfers, checks hold-while-stalled and the done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            held_v    = 1'b0;
            done_pend = 1'b0;
        end else begin
            logic [12:0] cur;
            logic [12:0] e;
            bit hs;
            cur = {out_last, out_addr, out_data};
            if (held_v) chk("hold_stable", {out_valid, cur}, {1'b1, held_word});
            if (done || done_pend) chk("done_pulse", done, done_pend);
            if (done) begin
                done_cnt++;
                done_k = cyc - t0 + 1;
            end
            hs = out_valid && out_ready && !abort;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", cur, e);
                end
                hs_count++;
                if (hs_count == 1) first_hs_k = cyc - t0 + 1;
                last_hs_k = cyc - t0 + 1;
            end
            done_pend = hs && out_last;
            held_v    = out_valid && !out_ready && !abort;
            held_word = cur;
        end
    end

    // Push the expected words, pulse start, then check cycle-1 state.
    task automatic start_dump(input logic [3:0] f, input logic [3:0] l);
        int n;
        int a;
        n = ((int'(l) - int'(f) + 16) % 16) + 1;
        for (int i = 0; i < n; i++) begin
            logic [3:0] a4;
            a  = (int'(f) + i) % 16;
            a4 = a[3:0];
            exp_q.push_back({(i == n - 1), a4, mdl[a]});
        end
        hs_count   = 0;
        first_hs_k = 0;
        last_hs_k  = 0;
        done_k     = 0;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0    = cyc;
        chk("cycle1_busy", busy, 1);
        chk("cycle1_rf_address", rf_address, f);
        chk("cycle1_valid", out_valid, 0);
    endtask

    // Drive out_ready per cycle until done, bounded by a cycle budget.
    // mode 0: always ready; 1: ready every third cycle; 2: ready from cycle 4.
    task automatic run_until_done(input int mode, input int live_k, input int budget);
        int base;
        int k;
        bit ok;
        base = done_cnt;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            k = cyc - t0 + 1;
            case (mode)
                1:       out_ready = (k % 3 == 1);
                2:       out_ready = (k >= 4);
                default: out_ready = 1'b1;
            endcase
            if (live_k != 0 && k == live_k) rf[7] = 8'h55;
            @(posedge clk); #1;
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        chk("dump_completes", ok, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_err      = 0;
        cyc        = 0;
        t0         = 0;
        done_cnt   = 0;
        hs_count   = 0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rf[i]  = 8'hA0 + 8'(i);
            mdl[i] = 8'hA0 + 8'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {rf_address, out_data, out_addr, out_last, out_valid, busy, done},
            25'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic run: 2..5 with out_ready held high.
        start_dump(4'd2, 4'd5);
        run_until_done(0, 0, 40);
        chk("basic_words", hs_count, 4);
        chk("basic_first_cycle", first_hs_k, 2);
        chk("basic_last_cycle", last_hs_k, 5);
        chk("basic_done_cycle", done_k, 6);
        chk("basic_idle", busy, 0);

        // Wrap through the top address.
        start_dump(4'd14, 4'd1);
        run_until_done(0, 0, 40);
        chk("wrap_words", hs_count, 4);

        // Full dump: last = first - 1.
        start_dump(4'd3, 4'd2);
        run_until_done(0, 0, 60);
        chk("full_words", hs_count, 16);
        chk("full_done_cycle", done_k, 18);

        // Single word.
        start_dump(4'd9, 4'd9);
        run_until_done(0, 0, 20);
        chk("single_words", hs_count, 1);

        // Backpressure.
        start_dump(4'd0, 4'd3);
        run_until_done(1, 0, 60);
        chk("bp_words", hs_count, 4);
        chk("bp_done_after_last", done_k, last_hs_k + 1);

        // Live write to a not-yet-loaded register.
        mdl[7] = 8'h55;
        start_dump(4'd0, 4'd7);
        run_until_done(2, 3, 60);
        chk("live_words", hs_count, 8);

        // Abort in cycle 3 of a full 0..15 dump.
        begin
            int base;
            base = done_cnt;
            start_dump(4'd0, 4'd15);
            @(posedge clk); #1;          // cycle 2
            @(posedge clk); #1;          // cycle 3
            abort = 1'b1;
            @(posedge clk); #1;          // cycle 4
            abort = 1'b0;
            chk("abort_valid", out_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_words", hs_count, 1);
            exp_q.delete();
            repeat (10) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, base);
        end

        // abort together with start in IDLE: start ignored.
        first_addr = 4'd1;
        last_addr  = 4'd2;
        start      = 1'b1;
        abort      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_idle", busy, 0);

        // start while busy is ignored.
        start_dump(4'd4, 4'd6);
        first_addr = 4'd9;
        last_addr  = 4'd12;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(0, 0, 40);
        chk("busy_start_words", hs_count, 3);

        // Asynchronous reset mid-transfer.
        start_dump(4'd0, 4'd15);
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs",
            {rf_address, out_data, out_addr, out_last, out_valid, busy, done}, 25'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        start_dump(4'd8, 4'd10);
        run_until_done(0, 0, 40);
        chk("post_reset_words", hs_count, 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit");
    end

endmodule
